// File: rtl/fire_pkg.sv
// fire_pkg: shared widths, trip points, indicator bit positions and heat FSM states
package fire_pkg;
    localparam int TEMP_W    = 8;
    localparam int TEMP_ON   = 46;
    localparam int TEMP_OFF  = 43;
    localparam int SMOKE_BIT = 0;
    localparam int HEAT_BIT  = 1;
    typedef enum logic {HEAT_COOL = 1'b0, HEAT_HOT = 1'b1} heat_state_t;
endpackage

// File: rtl/fire_sensor_conditioner_sync_debounce.sv
// sync_debounce: two-flop synchroniser followed by a DEBOUNCE-cycle change filter
//   clk, rst : clock, synchronous active-high reset
//   din      : asynchronous input
//   dout     : registered debounced level
module sync_debounce
    import fire_pkg::*;
#(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            // any cycle agreeing with the output restarts the run
            if (s2 != dout) begin
                if (cnt == LAST) begin
                    dout <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/fire_sensor_conditioner.sv
// fire_sensor_conditioner: debounced smoke flag, hysteretic heat flag and thermometer staleness
//   clk, rst        : clock, synchronous active-high reset
//   smoke_raw       : asynchronous smoke line, 1 = smoke
//   temp_valid      : one-cycle strobe qualifying temp_c
//   temp_c          : signed temperature sample in degrees C
//   fire_indicators : bit0 smoke confirmed, bit1 heat confirmed (registered)
//   temp_stale      : no temp_valid for TIMEOUT cycles
module fire_sensor_conditioner
    import fire_pkg::*;
#(
    parameter int TEMP_W   = fire_pkg::TEMP_W,
    parameter int TEMP_ON  = fire_pkg::TEMP_ON,
    parameter int TEMP_OFF = fire_pkg::TEMP_OFF,
    parameter int DEBOUNCE = 16,
    parameter int CONFIRM  = 3,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     smoke_raw,
    input  logic                     temp_valid,
    input  logic signed [TEMP_W-1:0] temp_c,
    output logic [1:0]               fire_indicators,
    output logic                     temp_stale
);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CONFIRM - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic signed [TEMP_W-1:0] ON_T  = TEMP_W'(TEMP_ON);
    localparam logic signed [TEMP_W-1:0] OFF_T = TEMP_W'(TEMP_OFF);
    heat_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic heat_q, smoke, qual, enter_stale;
    sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_smoke (
        .clk  (clk),
        .rst  (rst),
        .din  (smoke_raw),
        .dout (smoke)
    );
    always_comb begin
        // a sample qualifies when it argues for leaving the current state
        qual        = state == HEAT_COOL ? temp_c >= ON_T : temp_c <= OFF_T;
        timer_n     = temp_valid ? '0 : timer == T_MAX ? timer : timer + 1'b1;
        enter_stale = timer_n == T_MAX && timer != T_MAX;
        state_n     = state;
        cnt_n       = cnt;
        if (temp_valid) begin
            if (!qual) begin
                cnt_n = '0;
            end else if (cnt == C_LAST) begin
                state_n = state == HEAT_COOL ? HEAT_HOT : HEAT_COOL;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (enter_stale) begin
            // stale thermometer: drop partial evidence, hold the state
            cnt_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= HEAT_COOL;
            cnt    <= '0;
            timer  <= '0;
            heat_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            timer  <= timer_n;
            heat_q <= state_n == HEAT_HOT;
        end
    end
    assign temp_stale = timer == T_MAX;
    always_comb begin
        fire_indicators            = '0;
        fire_indicators[SMOKE_BIT] = smoke;
        fire_indicators[HEAT_BIT]  = heat_q;
    end
endmodule
